// File: rtl/cpu_disp_pkg.sv
// Shared constants for the LED scan display: digit count,
// blank pattern and the active-low hex segment table.
package cpu_disp_pkg;

   localparam int DISP_DIGITS = 8;
   localparam int IDX_W       = $clog2(DISP_DIGITS);

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Segments {g,f,e,d,c,b,a}, active-low, indexed by nibble.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble to seven-segment decoder (active-low).
// Ports: i_nibble (4), i_blank (1) -> o_seg (7) {g,f,e,d,c,b,a}.
module hex7seg_decode
   import cpu_disp_pkg::*;
(
   input  logic [3:0] i_nibble,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   assign o_seg = i_blank ? SEG_BLANK : HEX_SEG[i_nibble];

endmodule

// File: rtl/led_scan_display.sv
// Double-buffered 8-digit multiplexed hex display driver.
// Ports: clk, rst (async low), load, data_in[31:0], blank_lz
//        -> an[7:0], seg[6:0], dp, frame_done (all active-low
//        except frame_done, a one-cycle wrap pulse).
module led_scan_display
   import cpu_disp_pkg::*;
#(
   parameter int CLK_DIV = 50000,
   parameter int DIGITS  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] data_in,
   input  logic        blank_lz,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PW-1:0]    r_presc;
   logic [IDX_W-1:0] r_idx;
   logic [31:0]      r_shadow;
   logic [31:0]      r_disp;
   logic             r_pending;
   logic [7:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_frame_done;

   logic             w_tick;
   logic             w_frame;
   logic [IDX_W-1:0] w_idx_next;
   logic [31:0]      w_disp_next;
   logic             w_pending_next;
   logic [4:0]       w_shamt;
   logic [3:0]       w_nibble;
   logic             w_blank;
   logic [6:0]       w_seg;

   assign w_tick     = (r_presc == PW'(CLK_DIV - 1));
   assign w_frame    = w_tick && (r_idx == IDX_W'(DISP_DIGITS - 1));
   assign w_idx_next = w_tick ? r_idx + 1'b1 : r_idx;

   // A load coinciding with the boundary bypasses the shadow
   // so it is shown this frame and nothing stays pending.
   always_comb begin
      w_disp_next    = r_disp;
      w_pending_next = r_pending;
      if (w_frame) begin
         w_pending_next = 1'b0;
         if (load)
            w_disp_next = data_in;
         else if (r_pending)
            w_disp_next = r_shadow;
      end else if (load) begin
         w_pending_next = 1'b1;
      end
   end

   assign w_shamt  = {w_idx_next, 2'b00};
   assign w_nibble = w_disp_next[w_shamt +: 4];

   // Digit k>0 blanks when it and every higher nibble is zero.
   always_comb begin
      w_blank = 1'b0;
      if (blank_lz && (w_idx_next != '0))
         w_blank = ((w_disp_next >> w_shamt) == 32'd0);
   end

   hex7seg_decode u_dec (
      .i_nibble (w_nibble),
      .i_blank  (w_blank),
      .o_seg    (w_seg)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_presc      <= '0;
         r_idx        <= '0;
         r_shadow     <= '0;
         r_disp       <= '0;
         r_pending    <= 1'b0;
         r_an         <= 8'hFF;
         r_seg        <= SEG_BLANK;
         r_frame_done <= 1'b0;
      end else begin
         r_presc      <= w_tick ? '0 : r_presc + 1'b1;
         r_idx        <= w_idx_next;
         r_disp       <= w_disp_next;
         r_pending    <= w_pending_next;
         r_frame_done <= w_frame;
         if (load)
            r_shadow <= data_in;
         if (w_tick) begin
            r_an  <= ~(DIGITS'(1) << w_idx_next);
            r_seg <= w_seg;
         end
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = 1'b1;
   assign frame_done = r_frame_done;

endmodule

// File: doc/led_scan_display.md
Name: led_scan_display

Overview:
- Consumer side of the 32-bit LED data word produced by the syscall unit, for example the a0 value latched on a v0=34 display syscall.
- Captures the word on a load strobe and drives it onto an 8-digit multiplexed, common-anode seven-segment display as hexadecimal.
- Double-buffered so a new value only takes effect at a frame boundary, which prevents mixed old/new digits within one frame.
- Sits between the CPU syscall block and the board display pins.

Parameters:
- CLK_DIV, default 50000: clock cycles per digit slot. Legal range is 1 or more; 1 means advance every cycle.
- DIGITS, default 8: number of digits. Fixed at 8 in this revision; any other value is unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; capture data_in.
- data_in  in  32  word to display; nibble k is shown on digit k (digit 0 = least significant nibble).
- blank_lz  in  1  when 1, blank leading zero digits.
- an  out  8  digit enables, active-low, one-hot-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; held at 1 (off) permanently.
- frame_done  out  1  one-cycle pulse each time the scan wraps from digit 7 to digit 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - shadow, disp and pending = 0; prescaler and idx = 0.
  - an = 8'hFF; seg = 7'h7F; dp = 1; frame_done = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - tick is asserted in the cycle where the count equals CLK_DIV-1.
- Scan index (idx, 3 bits):
  - On tick, idx <= idx+1 (7 wraps to 0).
  - A frame boundary is a tick with idx==7.
  - an and seg are registered. On tick they update to present digit idx_next, so outputs change on the same edge idx advances.
  - Between ticks all outputs hold.
  - After reset, an stays 8'hFF until the first tick. That tick selects digit 1, not digit 0.
- Load:
  - On load=1, shadow <= data_in and pending <= 1.
  - Back-to-back loads: the last one before the boundary wins.
- Frame boundary:
  - If pending, disp <= shadow and pending <= 0.
  - frame_done = 1 for that single cycle.
  - The digit-0 seg value produced on this edge uses the new disp value, selected combinationally from the next-state value.
- Load in the same cycle as a frame boundary:
  - disp <= data_in directly, shadow <= data_in, pending stays 0.
- Segment decode, nibble to seg (hex, active-low):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
  - Blank digit → 7F.
- Leading-zero blanking:
  - With blank_lz=1, digit k (k≥1) is blanked when nibbles k..7 of disp are all zero.
  - A blanked digit drives seg=7F, but its an bit is still driven low.
  - Digit 0 is never blanked.
  - blank_lz is sampled at each tick; no synchronizer is required.
- Reset mid-frame: everything returns to its reset value immediately. Any pending value is discarded.

Decomposition:
- Shared package (cpu_disp_pkg):
  - SEG_BLANK = 7'h7F.
  - The 16-entry hex segment constant table.
  - DISP_DIGITS = 8.
- One sub-module: hex7seg_decode (combinational, 4-bit nibble plus blank flag → 7-bit seg), instantiated once on the selected nibble.
- The prescaler, index counter and buffering stay in the top module.

Test Plan (CLK_DIV=4, blank_lz=0 unless stated):
- Reset, then 12 cycles idle → an=FF, seg=7F, dp=1 until the first tick (cycle 4). Then an=FD, seg=40, because disp is 0.
- load data_in=32'h0000_0022 (a0=34 pattern) in cycle 2 → display is unchanged until the first frame boundary (32 cycles after reset). Digit 0: an=FE, seg=24. Digit 1: an=FD, seg=24. Digits 2-7: seg=40. frame_done pulses once per 32 cycles.
- load 32'h89AB_CDEF mid-frame, then load 32'h1234_5678 before the boundary → after the boundary, digit 0 shows 8 (seg=00) and digit 7 shows 1 (seg=79). 89ABCDEF is never displayed.
- load 32'hFFFF_FFFF asserted exactly on the boundary tick → the digit-0 output on that edge is seg=0E, and pending remains 0.
- blank_lz=1 with disp=32'h0000_0005 → digit 0 shows seg=12; digits 1-7 show seg=7F with their an bit low. A second case, disp=32'h0010_0000: digits 6-7 are blank, digit 5 shows 79, and digits 0-4 show 40.
- Assert rst low mid-frame after a load → an=FF and seg=7F immediately (asynchronous). After release, the display shows 0 and the pre-reset value never appears.
